// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester and shared-ALU signals of the two-port ALU arbiter
interface alu_arbiter_if;
    // requester side
    logic        i_stb0;
    logic        i_stb1;
    logic [3:0]  i_op0;
    logic [3:0]  i_op1;
    logic [31:0] i_a0;
    logic [31:0] i_b0;
    logic [31:0] i_a1;
    logic [31:0] i_b1;
    logic        o_busy0;
    logic        o_busy1;
    logic        o_valid0;
    logic        o_valid1;
    logic [31:0] o_c0;
    logic [31:0] o_c1;
    logic [3:0]  o_f0;
    logic [3:0]  o_f1;
    logic        o_err0;
    logic        o_err1;
    // shared ALU side
    logic        o_alu_stb;
    logic [3:0]  o_alu_op;
    logic [31:0] o_alu_a;
    logic [31:0] o_alu_b;
    logic        o_alu_abort;
    logic        i_alu_valid;
    logic        i_alu_busy;
    logic [31:0] i_alu_c;
    logic [3:0]  i_alu_f;

    modport slave (
        input  i_stb0, i_stb1, i_op0, i_op1, i_a0, i_b0, i_a1, i_b1,
        input  i_alu_valid, i_alu_busy, i_alu_c, i_alu_f,
        output o_busy0, o_busy1, o_valid0, o_valid1, o_c0, o_c1,
        output o_f0, o_f1, o_err0, o_err1,
        output o_alu_stb, o_alu_op, o_alu_a, o_alu_b, o_alu_abort
    );

    modport master (
        output i_stb0, i_stb1, i_op0, i_op1, i_a0, i_b0, i_a1, i_b1,
        output i_alu_valid, i_alu_busy, i_alu_c, i_alu_f,
        input  o_busy0, o_busy1, o_valid0, o_valid1, o_c0, o_c1,
        input  o_f0, o_f1, o_err0, o_err1,
        input  o_alu_stb, o_alu_op, o_alu_a, o_alu_b, o_alu_abort
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
module alu_arbiter #(
    parameter int TIMEOUT      = 64,
    parameter bit OPT_LOWPOWER = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [1:0]         pend_q, pend_d;
    logic [1:0][3:0]    hop_q, hop_d;
    logic [1:0][31:0]   ha_q, ha_d;
    logic [1:0][31:0]   hb_q, hb_d;
    logic               last_q, last_d;
    logic               owner_q, owner_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               alu_stb_q, alu_stb_d;
    logic [3:0]         alu_op_q, alu_op_d;
    logic [31:0]        alu_a_q, alu_a_d;
    logic [31:0]        alu_b_q, alu_b_d;
    logic               abort_q, abort_d;
    logic [1:0]         valid_q, valid_d;
    logic [1:0]         err_q, err_d;
    logic [1:0][31:0]   c_q, c_d;
    logic [1:0][3:0]    f_q, f_d;
    logic               gnt;

    // Next-state: request capture, grant selection, completion and timeout handling
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        hop_d     = hop_q;
        ha_d      = ha_q;
        hb_d      = hb_q;
        last_d    = last_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        alu_stb_d = 1'b0;
        alu_op_d  = OPT_LOWPOWER ? 4'd0  : alu_op_q;
        alu_a_d   = OPT_LOWPOWER ? 32'd0 : alu_a_q;
        alu_b_d   = OPT_LOWPOWER ? 32'd0 : alu_b_q;
        abort_d   = 1'b0;
        valid_d   = 2'b00;
        err_d     = err_q;
        c_d       = c_q;
        f_d       = f_q;
        gnt       = 1'b0;

        // a port is free (busy low) exactly when its pending flag is clear
        if (bus.i_stb0 && !pend_q[0]) begin
            pend_d[0] = 1'b1;
            hop_d[0]  = bus.i_op0;
            ha_d[0]   = bus.i_a0;
            hb_d[0]   = bus.i_b0;
        end
        if (bus.i_stb1 && !pend_q[1]) begin
            pend_d[1] = 1'b1;
            hop_d[1]  = bus.i_op1;
            ha_d[1]   = bus.i_a1;
            hb_d[1]   = bus.i_b1;
        end

        case (state_q)
            S_IDLE: begin
                if (pend_q != 2'b00 && !bus.i_alu_busy) begin
                    // on a tie the port not granted last time wins
                    gnt       = (pend_q == 2'b11) ? ~last_q : pend_q[1];
                    owner_d   = gnt;
                    last_d    = gnt;
                    alu_stb_d = 1'b1;
                    alu_op_d  = hop_q[gnt];
                    alu_a_d   = ha_q[gnt];
                    alu_b_d   = hb_q[gnt];
                    cnt_d     = 8'd0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                // a result on the final counted cycle still completes normally
                if (bus.i_alu_valid) begin
                    valid_d[owner_q] = 1'b1;
                    err_d[owner_q]   = 1'b0;
                    c_d[owner_q]     = bus.i_alu_c;
                    f_d[owner_q]     = bus.i_alu_f;
                    pend_d[owner_q]  = 1'b0;
                    state_d          = S_IDLE;
                end else if (cnt_q >= 8'(TIMEOUT - 1)) begin
                    valid_d[owner_q] = 1'b1;
                    err_d[owner_q]   = 1'b1;
                    c_d[owner_q]     = 32'd0;
                    f_d[owner_q]     = 4'd0;
                    pend_d[owner_q]  = 1'b0;
                    abort_d          = 1'b1;
                    state_d          = S_IDLE;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset drops any in-flight op without a response
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            pend_q    <= 2'b00;
            hop_q     <= '0;
            ha_q      <= '0;
            hb_q      <= '0;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            cnt_q     <= 8'd0;
            alu_stb_q <= 1'b0;
            alu_op_q  <= 4'd0;
            alu_a_q   <= 32'd0;
            alu_b_q   <= 32'd0;
            abort_q   <= 1'b0;
            valid_q   <= 2'b00;
            err_q     <= 2'b00;
            c_q       <= '0;
            f_q       <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            hop_q     <= hop_d;
            ha_q      <= ha_d;
            hb_q      <= hb_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            alu_stb_q <= alu_stb_d;
            alu_op_q  <= alu_op_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            abort_q   <= abort_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            c_q       <= c_d;
            f_q       <= f_d;
        end
    end

    assign bus.o_busy0     = pend_q[0];
    assign bus.o_busy1     = pend_q[1];
    assign bus.o_valid0    = valid_q[0];
    assign bus.o_valid1    = valid_q[1];
    assign bus.o_err0      = err_q[0];
    assign bus.o_err1      = err_q[1];
    assign bus.o_c0        = c_q[0];
    assign bus.o_c1        = c_q[1];
    assign bus.o_f0        = f_q[0];
    assign bus.o_f1        = f_q[1];
    assign bus.o_alu_stb   = alu_stb_q;
    assign bus.o_alu_op    = alu_op_q;
    assign bus.o_alu_a     = alu_a_q;
    assign bus.o_alu_b     = alu_b_q;
    assign bus.o_alu_abort = abort_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a delayed-response ALU model
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_arbiter_if bus_if();

    alu_arbiter #(.TIMEOUT(4), .OPT_LOWPOWER(1'b1)) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .bus      (bus_if)
    );

    typedef struct {
        logic [31:0] c;
        logic [3:0]  f;
        logic        err;
    } resp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } iss_t;

    resp_t exp0[$];
    resp_t exp1[$];
    iss_t  exp_iss[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int alu_delay = 1;
    int stb_cnt = 0;
    int abort_cnt = 0;
    int last_stb_cyc = 0;
    int last_v0_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        case (op)
            4'd2:    return a + b;
            4'd3:    return a - b;
            4'd4:    return a | b;
            4'd6:    return a * b;
            default: return 32'd0;
        endcase
    endfunction

    // ALU model: checks each issue against the expected order, answers alu_delay cycles later
    initial begin
        iss_t        e;
        int          cd;
        logic [31:0] rc;
        cd = 0;
        rc = 32'd0;
        bus_if.i_alu_valid = 1'b0;
        bus_if.i_alu_c     = 32'd0;
        bus_if.i_alu_f     = 4'd0;
        forever begin
            @(negedge clk);
            bus_if.i_alu_valid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus_if.i_alu_valid = 1'b1;
                    bus_if.i_alu_c     = rc;
                    bus_if.i_alu_f     = {1'b0, rc[31], 1'b0, (rc == 32'd0)};
                end
            end
            if (bus_if.o_alu_stb) begin
                if (exp_iss.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_issue: got op %0h with nothing expected", bus_if.o_alu_op);
                end else begin
                    e = exp_iss.pop_front();
                    chk("issue_op", 64'(bus_if.o_alu_op), 64'(e.op));
                    chk("issue_a", 64'(bus_if.o_alu_a), 64'(e.a));
                    chk("issue_b", 64'(bus_if.o_alu_b), 64'(e.b));
                end
                rc = alu_model(bus_if.o_alu_op, bus_if.o_alu_a, bus_if.o_alu_b);
                cd = alu_delay;
            end
        end
    end

    // Monitor: pops the expected response for every result pulse
    initial begin
        resp_t e;
        bit    outstanding;
        outstanding = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.o_alu_stb) begin
                stb_cnt++;
                last_stb_cyc = cyc;
                chk("single_outstanding", 64'(outstanding), 64'd0);
                outstanding = 1'b1;
            end else begin
                chk("lowpower_zero", {bus_if.o_alu_a, bus_if.o_alu_b} | 64'(bus_if.o_alu_op), 64'd0);
            end
            if (bus_if.o_alu_abort) abort_cnt++;
            if (bus_if.o_valid0) begin
                last_v0_cyc = cyc;
                chk("busy0_low_at_valid", 64'(bus_if.o_busy0), 64'd0);
                if (exp0.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid0: got c %0h with nothing expected", bus_if.o_c0);
                end else begin
                    e = exp0.pop_front();
                    chk("c0", 64'(bus_if.o_c0), 64'(e.c));
                    chk("f0", 64'(bus_if.o_f0), 64'(e.f));
                    chk("err0", 64'(bus_if.o_err0), 64'(e.err));
                end
            end
            if (bus_if.o_valid1) begin
                chk("busy1_low_at_valid", 64'(bus_if.o_busy1), 64'd0);
                if (exp1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid1: got c %0h with nothing expected", bus_if.o_c1);
                end else begin
                    e = exp1.pop_front();
                    chk("c1", 64'(bus_if.o_c1), 64'(e.c));
                    chk("f1", 64'(bus_if.o_f1), 64'(e.f));
                    chk("err1", 64'(bus_if.o_err1), 64'(e.err));
                end
            end
            if (bus_if.o_alu_abort || bus_if.o_valid0 || bus_if.o_valid1 ||
                (!bus_if.o_busy0 && !bus_if.o_busy1))
                outstanding = 1'b0;
        end
    end

    task automatic set0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus_if.i_stb0 = 1'b1;
        bus_if.i_op0  = op;
        bus_if.i_a0   = a;
        bus_if.i_b0   = b;
    endtask

    task automatic set1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus_if.i_stb1 = 1'b1;
        bus_if.i_op1  = op;
        bus_if.i_a1   = a;
        bus_if.i_b1   = b;
    endtask

    task automatic clr();
        bus_if.i_stb0 = 1'b0;
        bus_if.i_stb1 = 1'b0;
    endtask

    task automatic push_iss(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        iss_t e;
        e.op = op;
        e.a  = a;
        e.b  = b;
        exp_iss.push_back(e);
    endtask

    task automatic push_rsp(input int port, input logic [31:0] c, input logic [3:0] f,
                            input logic err);
        resp_t e;
        e.c   = c;
        e.f   = f;
        e.err = err;
        if (port == 0) exp0.push_back(e);
        else           exp1.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp0.size() == 0 && exp1.size() == 0 && exp_iss.size() == 0 &&
                !bus_if.o_busy0 && !bus_if.o_busy1) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got pending %0d/%0d want 0/0", name, exp0.size(), exp1.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t;
        int s0;
        int a0;
        bit seen;
        rst_n = 1'b0;
        clr();
        bus_if.i_op0 = 4'd0;
        bus_if.i_op1 = 4'd0;
        bus_if.i_a0  = 32'd0;
        bus_if.i_b0  = 32'd0;
        bus_if.i_a1  = 32'd0;
        bus_if.i_b1  = 32'd0;
        bus_if.i_alu_busy = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_busy", {62'd0, bus_if.o_busy1, bus_if.o_busy0}, 64'd0);
        chk("rst_valid", {62'd0, bus_if.o_valid1, bus_if.o_valid0}, 64'd0);
        chk("rst_stb_abort", {62'd0, bus_if.o_alu_stb, bus_if.o_alu_abort}, 64'd0);
        chk("rst_c", {bus_if.o_c1, bus_if.o_c0}, 64'd0);
        chk("rst_f_err", {56'd0, bus_if.o_f1, bus_if.o_f0} | {62'd0, bus_if.o_err1, bus_if.o_err0}, 64'd0);

        // simultaneous strobes straight out of reset: port0 wins the first tie
        rst_n = 1'b1;
        set0(4'd3, 32'd3, 32'd3);
        set1(4'd4, 32'd1, 32'd2);
        push_iss(4'd3, 32'd3, 32'd3);
        push_iss(4'd4, 32'd1, 32'd2);
        push_rsp(0, 32'd0, 4'b0001, 1'b0);
        push_rsp(1, 32'd3, 4'b0000, 1'b0);
        @(negedge clk);
        clr();
        wait_idle("tie1", 40);

        // second tie: port1 went last, so port0 again first
        set0(4'd2, 32'd1, 32'd1);
        set1(4'd2, 32'd2, 32'd2);
        push_iss(4'd2, 32'd1, 32'd1);
        push_iss(4'd2, 32'd2, 32'd2);
        push_rsp(0, 32'd2, 4'b0000, 1'b0);
        push_rsp(1, 32'd4, 4'b0000, 1'b0);
        @(negedge clk);
        clr();
        wait_idle("tie2", 40);

        // single ADD latency; a strobe while busy must be ignored
        set0(4'd2, 32'd5, 32'd7);
        push_iss(4'd2, 32'd5, 32'd7);
        push_rsp(0, 32'd12, 4'b0000, 1'b0);
        t = cyc + 1;
        @(negedge clk);
        chk("busy0_after_accept", 64'(bus_if.o_busy0), 64'd1);
        set0(4'd2, 32'd99, 32'd99);
        @(negedge clk);
        clr();
        wait_idle("add", 40);
        chk("add_stb_latency", 64'(last_stb_cyc), 64'(t + 1));
        chk("add_valid_latency", 64'(last_v0_cyc), 64'(t + 3));

        // ALU busy blocks issue; port1 wins the tie since port0 went last
        bus_if.i_alu_busy = 1'b1;
        s0 = stb_cnt;
        set1(4'd6, 32'd6, 32'd7);
        push_iss(4'd6, 32'd6, 32'd7);
        push_rsp(1, 32'd42, 4'b0000, 1'b0);
        @(negedge clk);
        clr();
        set0(4'd2, 32'd10, 32'd20);
        push_iss(4'd2, 32'd10, 32'd20);
        push_rsp(0, 32'd30, 4'b0000, 1'b0);
        @(negedge clk);
        clr();
        @(negedge clk);
        chk("no_issue_while_alu_busy", 64'(stb_cnt), 64'(s0));
        bus_if.i_alu_busy = 1'b0;
        wait_idle("alu_busy", 40);

        // result on the last counted WAIT cycle wins over the timeout
        a0 = abort_cnt;
        alu_delay = 3;
        set0(4'd2, 32'd8, 32'd8);
        push_iss(4'd2, 32'd8, 32'd8);
        push_rsp(0, 32'd16, 4'b0000, 1'b0);
        @(negedge clk);
        clr();
        wait_idle("edge_valid", 40);
        chk("no_abort_on_edge_valid", 64'(abort_cnt), 64'(a0));

        // one cycle too late: timeout with error, then the late result is ignored
        alu_delay = 4;
        set0(4'd2, 32'd9, 32'd9);
        push_iss(4'd2, 32'd9, 32'd9);
        push_rsp(0, 32'd0, 4'b0000, 1'b1);
        @(negedge clk);
        clr();
        wait_idle("timeout", 40);
        repeat (4) @(negedge clk);
        chk("abort_one_pulse", 64'(abort_cnt), 64'(a0 + 1));
        chk("c0_holds_after_late_valid", 64'(bus_if.o_c0), 64'd0);

        // reset while WAIT: no response, no abort, then a normal op
        alu_delay = 3;
        a0 = abort_cnt;
        set1(4'd2, 32'd1, 32'd2);
        push_iss(4'd2, 32'd1, 32'd2);
        @(negedge clk);
        clr();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("busy_after_wait_reset", {62'd0, bus_if.o_busy1, bus_if.o_busy0}, 64'd0);
        repeat (5) @(negedge clk);
        chk("no_abort_on_reset", 64'(abort_cnt), 64'(a0));
        alu_delay = 1;
        set1(4'd2, 32'd4, 32'd5);
        push_iss(4'd2, 32'd4, 32'd5);
        push_rsp(1, 32'd9, 4'b0000, 1'b0);
        @(negedge clk);
        clr();
        wait_idle("after_reset", 40);

        // re-strobe in the o_valid0 cycle
        set0(4'd2, 32'd3, 32'd4);
        push_iss(4'd2, 32'd3, 32'd4);
        push_rsp(0, 32'd7, 4'b0000, 1'b0);
        @(negedge clk);
        clr();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.o_valid0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("restrobe_first_valid_seen", 64'(seen), 64'd1);
        set0(4'd2, 32'd100, 32'd1);
        push_iss(4'd2, 32'd100, 32'd1);
        push_rsp(0, 32'd101, 4'b0000, 1'b0);
        @(negedge clk);
        clr();
        wait_idle("restrobe", 40);
        repeat (4) @(negedge clk);
        chk("no_leftover_rsp", 64'(exp0.size() + exp1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: max WAIT cycles before an op is aborted; legal range 4..255.
REQ-002 Parameter OPT_LOWPOWER, default 1: when 1, o_alu_op/a/b are zero whenever o_alu_stb is low.
REQ-003 i_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 i_reset_n  in  1  synchronous, active-low reset.
REQ-005 i_stb0, i_stb1  in  1 each  requester N presents an op.
REQ-006 i_op0, i_op1  in  4 each  ALU opcode; i_a0, i_b0, i_a1, i_b1  in  32 each  operands.
REQ-007 o_busy0, o_busy1  out  1 each  requester N may not strobe.
REQ-008 o_valid0, o_valid1  out  1 each  one-cycle result pulse to requester N.
REQ-009 o_c0, o_c1  out  32 each  result; o_f0, o_f1  out  4 each  flags {V,N,C,Z}; o_err0, o_err1  out  1 each  timeout indication, qualified by o_validN.
REQ-010 o_alu_stb  out  1; o_alu_op  out  4; o_alu_a, o_alu_b  out  32 each  shared-ALU issue port.
REQ-011 i_alu_valid  in  1; i_alu_busy  in  1; i_alu_c  in  32; i_alu_f  in  4  shared-ALU result port.
REQ-012 o_alu_abort  out  1  one-cycle pulse telling the ALU to discard in-flight work.

Function
REQ-013 Each port SHALL have a holding register (op, a, b, pending flag); i_stbN is accepted on a clock where i_stbN && !o_busyN.
REQ-014 o_busyN SHALL be high while port N is pending or in flight, and low otherwise, including the cycle o_validN pulses.
REQ-015 A new i_stbN SHALL be accepted in the same cycle o_validN pulses.
REQ-016 i_stbN while o_busyN is high SHALL be ignored.
REQ-017 FSM states SHALL be IDLE and WAIT.
REQ-018 In IDLE with any port pending and !i_alu_busy, the arbiter SHALL grant one port, register its op/a/b to the ALU port with o_alu_stb=1 for exactly one cycle, and enter WAIT.
REQ-019 Grants SHALL be round-robin: a last-grant pointer selects the other port on a tie; a sole pending port is granted regardless of the pointer.
REQ-020 The pointer SHALL update on each grant.
REQ-021 In IDLE with i_alu_busy high, no grant SHALL be issued.
REQ-022 In WAIT on i_alu_valid, the arbiter SHALL on the next cycle drive o_cN=i_alu_c, o_fN=i_alu_f, o_errN=0 and o_validN=1 for the owner, clear the owner's pending flag, and return to IDLE.
REQ-023 Latency for a single-cycle ALU op: i_stbN at edge T, o_alu_stb high after edge T+1, i_alu_valid sampled at T+2, o_validN high after edge T+3.
REQ-024 A WAIT cycle counter SHALL reset on grant; if it reaches TIMEOUT without i_alu_valid, the owner gets o_validN=1, o_errN=1, o_cN=0, o_fN=0; o_alu_abort pulses one cycle; state returns to IDLE.
REQ-025 i_alu_valid arriving in the same cycle the count reaches TIMEOUT SHALL win, completing normally with no error.
REQ-026 i_alu_valid in IDLE SHALL be ignored, with no output change.
REQ-027 o_cN/o_fN SHALL hold their last values between o_validN pulses.
REQ-028 At most one op SHALL be outstanding at the ALU.
REQ-029 The counter SHALL saturate and not wrap.

Reset
REQ-030 While !i_reset_n, at the clock edge: state=IDLE; pending flags, counter, all o_valid, o_err, o_busy, o_alu_stb and o_alu_abort cleared.
REQ-031 Reset SHALL clear o_c0/1, o_f0/1, o_alu_op/a/b and set the pointer so port 0 wins the first tie.
REQ-032 Reset during WAIT SHALL drop the in-flight op silently: no o_validN, no o_alu_abort.
REQ-033 The first grant SHALL be possible on the cycle after i_reset_n rises.

Verification
REQ-034 Port0 ADD (op 2) a=5, b=7, ALU valid 1 cycle after stb -> o_alu_stb at T+1, o_valid0 at T+3, o_c0=12, o_f0=0000, o_busy0 low at T+3.
REQ-035 Both ports strobe the same cycle after reset (port0 SUB 3-3, port1 OR 1|2) -> port0 granted first, o_c0=0 with Z=1; then port1, o_c1=3; next tie grants port0.
REQ-036 Port1 MPY with i_alu_busy high for 3 cycles and port0 strobing meanwhile -> no o_alu_stb until busy drops and port1 result returns; then port0 is issued.
REQ-037 TIMEOUT=4, ALU never responds -> after 4 WAIT cycles o_valid0=1, o_err0=1, o_c0=0, o_alu_abort one pulse, state IDLE; a late i_alu_valid is ignored.
REQ-038 i_reset_n low for one cycle during WAIT -> no o_validN, all busy low, the next request completes normally.
REQ-039 Port0 re-strobes in its o_valid0 cycle -> accepted; the second result is returned with no lost or duplicated pulse.
